// File: rtl/alu_pkg.sv
// Shared ALU definitions for the decode stage, the EX ALU and the mul/div unit.
//   alu_op_e  : 5-bit ALU operation encoding
//   alu_dec_t : decoded payload (op, is_m, illegal)
//   OPC_*     : major opcodes decoded here, F7_* : funct7 classes
package alu_pkg;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned OPC_W = 7;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17,
    ALU_NOP    = 5'd30,
    ALU_ILL    = 5'd31
  } alu_op_e;

  localparam logic [OPC_W-1:0] OPC_OP    = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    alu_op_e op;
    logic    is_m;
    logic    illegal;
  } alu_dec_t;

endpackage

// File: rtl/alu_dec_comb.sv
// Pure combinational OP / OP-IMM decoder to a 5-bit ALU operation.
//   EN_M    : 1 decodes the M extension, 0 treats it as illegal
//   opcode, funct3, funct7 : instruction fields
//   op, is_m, illegal      : decoded result
module alu_dec_comb
  import alu_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    op,
  output logic       is_m,
  output logic       illegal
);

  always_comb begin
    op   = ALU_NOP;
    is_m = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (funct7)
          F7_BASE: begin
            case (funct3)
              3'b000:  op = ALU_ADD;
              3'b001:  op = ALU_SLL;
              3'b010:  op = ALU_SLT;
              3'b011:  op = ALU_SLTU;
              3'b100:  op = ALU_XOR;
              3'b101:  op = ALU_SRL;
              3'b110:  op = ALU_OR;
              default: op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            case (funct3)
              3'b000:  op = ALU_SUB;
              3'b101:  op = ALU_SRA;
              default: op = ALU_ILL;
            endcase
          end
          F7_MULDIV: begin
            // funct3 indexes MUL..REMU directly, contiguous from ALU_MUL
            if (EN_M) begin
              op   = alu_op_e'(OP_W'(ALU_MUL) + OP_W'(funct3));
              is_m = 1'b1;
            end else begin
              op = ALU_ILL;
            end
          end
          default: op = ALU_ILL;
        endcase
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b000:  op = ALU_ADD;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b110:  op = ALU_OR;
          3'b111:  op = ALU_AND;
          3'b001:  op = (funct7 == F7_BASE) ? ALU_SLL : ALU_ILL;
          default: op = (funct7 == F7_BASE) ? ALU_SRL :
                        (funct7 == F7_ALT)  ? ALU_SRA : ALU_ILL;
        endcase
      end
      default: op = ALU_NOP;
    endcase
    illegal = (op == ALU_ILL);
  end

endmodule

// File: rtl/alu_dec_stage.sv
// Registered ALU decode stage between ID and EX with valid/ready handshake,
// optional two-entry skid buffer, flush and saturating illegal-op counter.
//   clk, rst (sync, active high), flush
//   in_valid/in_ready, opcode/funct3/funct7/in_tag : upstream side
//   out_valid/out_ready, alu_op/is_m/illegal/out_tag : EX side
//   illegal_cnt : illegal ops delivered, saturating
module alu_dec_stage
  import alu_pkg::*;
#(
  parameter bit          EN_M  = 1'b1,
  parameter bit          SKID  = 1'b1,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  alu_op,
  output logic             is_m,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  alu_dec_t             dec;
  alu_dec_t             out_q;
  alu_dec_t             skid_q;
  logic [TAG_W-1:0]     skid_tag;
  logic                 skid_valid;
  logic                 accept;
  logic                 drain;

  alu_dec_comb #(.EN_M(EN_M)) u_dec (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .op      (dec.op),
    .is_m    (dec.is_m),
    .illegal (dec.illegal)
  );

  // Output register can take a new entry this edge
  assign drain    = !out_valid || out_ready;
  assign in_ready = SKID ? !skid_valid : drain;
  assign accept   = in_valid && in_ready;

  assign alu_op  = out_q.op;
  assign is_m    = out_q.is_m;
  assign illegal = out_q.illegal;

  // Output and skid entries; skid always drains ahead of new input
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_q      <= '{op: ALU_NOP, is_m: 1'b0, illegal: 1'b0};
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '{op: ALU_NOP, is_m: 1'b0, illegal: 1'b0};
      skid_tag   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_q      <= skid_q;
        out_tag    <= skid_tag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_q     <= dec;
        out_tag   <= in_tag;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (SKID && accept) begin
      skid_valid <= 1'b1;
      skid_q     <= dec;
      skid_tag   <= in_tag;
    end
  end

  // Count delivered illegal ops, holding at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (out_valid && out_ready && out_q.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_dec_stage.sv
// Directed self-checking bench for alu_dec_stage.
// dut_a: EN_M=1, SKID=1, CNT_W=4; dut_b: EN_M=0, SKID=0, CNT_W=4.
module tb_alu_dec_stage;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] in_tag;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_is_m, a_illegal;
  logic [4:0] a_alu_op, a_out_tag;
  logic [3:0] a_cnt;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_is_m, b_illegal;
  logic [4:0] b_alu_op, b_out_tag;
  logic [3:0] b_cnt;

  int checks;
  int failures;

  alu_dec_stage #(.EN_M(1'b1), .SKID(1'b1), .TAG_W(5), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .alu_op(a_alu_op), .is_m(a_is_m), .illegal(a_illegal),
    .out_tag(a_out_tag), .illegal_cnt(a_cnt)
  );

  alu_dec_stage #(.EN_M(1'b0), .SKID(1'b0), .TAG_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .alu_op(b_alu_op), .is_m(b_is_m), .illegal(b_illegal),
    .out_tag(b_out_tag), .illegal_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] tag);
    opcode = opc; funct3 = f3; funct7 = f7; in_tag = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_alu_op !== 5'd30) begin failures++; $display("FAIL reset_alu_op: got %0d expected 30", a_alu_op); end
    checks++; if (a_is_m !== 1'b0 || a_illegal !== 1'b0) begin failures++; $display("FAIL reset_flags: got is_m=%b illegal=%b expected 0 0", a_is_m, a_illegal); end
    checks++; if (a_out_tag !== 5'd0) begin failures++; $display("FAIL reset_out_tag: got %0d expected 0", a_out_tag); end
    checks++; if (a_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
    checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_b: got in_ready=%b out_valid=%b expected 1 0", b_in_ready, b_out_valid); end
  endtask

  task automatic test_sub();
    a_out_ready = 1'b1;
    set_in(7'b0110011, 3'b000, 7'b0100000, 5'd7);
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL sub_valid: got %b expected 1", a_out_valid); end
    checks++; if (a_alu_op !== 5'd1) begin failures++; $display("FAIL sub_op: got %0d expected 1", a_alu_op); end
    checks++; if (a_out_tag !== 5'd7) begin failures++; $display("FAIL sub_tag: got %0d expected 7", a_out_tag); end
    checks++; if (a_illegal !== 1'b0) begin failures++; $display("FAIL sub_illegal: got %b expected 0", a_illegal); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL sub_drain: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_decode();
    logic [6:0] v_opc [9] = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0000011, 7'b0110011,
                              7'b0010011, 7'b0110011, 7'b0110011, 7'b0010011};
    logic [2:0] v_f3  [9] = '{3'b100, 3'b101, 3'b001, 3'b000, 3'b011, 3'b000, 3'b111, 3'b001, 3'b101};
    logic [6:0] v_f7  [9] = '{7'b0000001, 7'b0100000, 7'b0100000, 7'b0000000, 7'b0000000,
                              7'b1111111, 7'b0000001, 7'b0100000, 7'b0000000};
    logic [4:0] v_op  [9] = '{5'd14, 5'd7, 5'd31, 5'd30, 5'd9, 5'd0, 5'd17, 5'd31, 5'd6};
    logic       v_m   [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       v_ill [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    a_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_in(v_opc[i], v_f3[i], v_f7[i], 5'(i + 10));
      a_in_valid = 1'b1;
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_alu_op !== v_op[i] || a_is_m !== v_m[i] ||
          a_illegal !== v_ill[i] || a_out_tag !== 5'(i + 10)) begin
        failures++;
        $display("FAIL decode[%0d]: got v=%b op=%0d m=%b ill=%b tag=%0d expected v=1 op=%0d m=%b ill=%b tag=%0d",
                 i, a_out_valid, a_alu_op, a_is_m, a_illegal, a_out_tag, v_op[i], v_m[i], v_ill[i], i + 10);
      end
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_cnt !== 4'd2) begin failures++; $display("FAIL decode_cnt: got %0d expected 2", a_cnt); end
  endtask

  task automatic test_no_m();
    b_out_ready = 1'b1;
    set_in(7'b0110011, 3'b100, 7'b0000001, 5'd3);
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    checks++; if (b_alu_op !== 5'd31 || b_illegal !== 1'b1 || b_is_m !== 1'b0) begin failures++; $display("FAIL nom_decode: got op=%0d ill=%b m=%b expected 31 1 0", b_alu_op, b_illegal, b_is_m); end
    checks++; if (b_cnt !== 4'd0) begin failures++; $display("FAIL nom_cnt_before: got %0d expected 0", b_cnt); end
    tick();
    checks++; if (b_cnt !== 4'd1) begin failures++; $display("FAIL nom_cnt_after: got %0d expected 1", b_cnt); end
    // single-entry mode: in_ready follows out_ready combinationally
    set_in(7'b0110011, 3'b000, 7'b0000000, 5'd4);
    b_in_valid = 1'b1;
    b_out_ready = 1'b0;
    tick();
    b_in_valid = 1'b0;
    checks++; if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin failures++; $display("FAIL noskid_stall: got v=%b in_ready=%b expected 1 0", b_out_valid, b_in_ready); end
    b_out_ready = 1'b1;
    #1;
    checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL noskid_comb_ready: got %b expected 1", b_in_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b0;
    set_in(7'b0110011, 3'b000, 7'b0000000, 5'd1);
    a_in_valid = 1'b1;
    tick();
    checks++; if (a_alu_op !== 5'd0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL skid_first: got op=%0d in_ready=%b expected 0 1", a_alu_op, a_in_ready); end
    set_in(7'b0110011, 3'b100, 7'b0000000, 5'd2);
    tick();
    checks++; if (a_alu_op !== 5'd0 || a_out_tag !== 5'd1 || a_in_ready !== 1'b0) begin failures++; $display("FAIL skid_held: got op=%0d tag=%0d in_ready=%b expected 0 1 0", a_alu_op, a_out_tag, a_in_ready); end
    set_in(7'b0110011, 3'b111, 7'b0000000, 5'd3);
    tick();
    checks++; if (a_alu_op !== 5'd0 || a_out_tag !== 5'd1 || a_in_ready !== 1'b0) begin failures++; $display("FAIL skid_stall3: got op=%0d tag=%0d in_ready=%b expected 0 1 0", a_alu_op, a_out_tag, a_in_ready); end
    a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_alu_op !== 5'd4 || a_out_tag !== 5'd2 || a_in_ready !== 1'b1) begin failures++; $display("FAIL skid_second: got v=%b op=%0d tag=%0d in_ready=%b expected 1 4 2 1", a_out_valid, a_alu_op, a_out_tag, a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_alu_op !== 5'd2 || a_out_tag !== 5'd3) begin failures++; $display("FAIL skid_third: got v=%b op=%0d tag=%0d expected 1 2 3", a_out_valid, a_alu_op, a_out_tag); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL skid_empty: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    set_in(7'b0110011, 3'b000, 7'b0000000, 5'd4);
    a_in_valid = 1'b1;
    tick();
    set_in(7'b0110011, 3'b000, 7'b0100000, 5'd5);
    tick();
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL flush_full: got in_ready=%b expected 0", a_in_ready); end
    set_in(7'b0110011, 3'b110, 7'b0000000, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_clear: got v=%b in_ready=%b expected 0 1", a_out_valid, a_in_ready); end
    a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost: got %b expected 0", a_out_valid); end
    // flush beats an accept into an empty stage
    set_in(7'b0110011, 3'b000, 7'b0000000, 5'd9);
    a_in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_accept: got %b expected 0", a_out_valid); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_cnt !== 4'd2) begin failures++; $display("FAIL flush_after: got v=%b cnt=%0d expected 0 2", a_out_valid, a_cnt); end
  endtask

  task automatic test_saturate();
    // reset while stalled with both entries full
    a_out_ready = 1'b0;
    set_in(7'b0010011, 3'b001, 7'b0100000, 5'd1);
    a_in_valid = 1'b1;
    tick(); tick();
    a_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_alu_op !== 5'd30 || a_cnt !== 4'd0) begin failures++; $display("FAIL rst_stall: got v=%b in_ready=%b op=%0d cnt=%0d expected 0 1 30 0", a_out_valid, a_in_ready, a_alu_op, a_cnt); end
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    for (int t = 1; t <= 19; t++) begin
      tick();
      if (t == 10) begin
        checks++; if (a_cnt !== 4'd9) begin failures++; $display("FAIL sat_mid: got %0d expected 9", a_cnt); end
      end
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold: got %0d expected 15", a_cnt); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; in_tag = '0;
    test_reset();
    test_sub();
    test_decode();
    test_no_m();
    test_back_to_back();
    test_flush();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
